// File: rtl/fixup_pkg.sv
// ============================================================================
// fixup_pkg : shared constants and slice helper for the fixup channel pipe
// Revision  : 1.0
// ============================================================================
`default_nettype none

package fixup_pkg;

  localparam int FIXUP_MAX_DEPTH = 8;

  function automatic int ch_slice(input int c, input int w);
    return c * w;
  endfunction

endpackage

`default_nettype wire

// File: rtl/fixup_pipe_stage.sv
// ============================================================================
// fixup_pipe_stage : one elastic valid/ready register stage
// Revision         : 1.0
// ============================================================================
`default_nettype none

module fixup_pipe_stage
  import fixup_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             up_valid,
  input  logic [WIDTH-1:0] up_data,
  input  logic             dn_ready,
  output logic             valid,
  output logic [WIDTH-1:0] data,
  output logic             up_ready
);

  logic             valid_q, valid_d;
  logic [WIDTH-1:0] data_q, data_d;

  // An empty stage accepts regardless of downstream, so bubbles collapse.
  assign up_ready = ~valid_q | dn_ready;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (up_ready) begin
      valid_d = up_valid;
      if (up_valid) begin
        data_d = up_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid = valid_q;
  assign data  = data_q;

endmodule

`default_nettype wire

// File: rtl/fixup_chan_pipe.sv
// ============================================================================
// fixup_chan_pipe : NUM_CH independent DEPTH-stage elastic pipes with counters
// Revision        : 1.0
// ============================================================================
`default_nettype none

module fixup_chan_pipe
  import fixup_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int NUM_CH = 4,
  parameter int DEPTH  = 2,
  parameter int CNT_W  = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  input  logic [NUM_CH-1:0]       in_valid,
  output logic [NUM_CH-1:0]       in_ready,
  input  logic [NUM_CH*WIDTH-1:0] in_data,
  output logic [NUM_CH-1:0]       out_valid,
  input  logic [NUM_CH-1:0]       out_ready,
  output logic [NUM_CH*WIDTH-1:0] out_data,
  output logic [NUM_CH*CNT_W-1:0] xfer_cnt
);

  if (DEPTH < 0 || DEPTH > FIXUP_MAX_DEPTH) begin : g_depth_check
    $error("fixup_chan_pipe: DEPTH out of range");
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    localparam int DLO = ch_slice(c, WIDTH);
    localparam int CLO = ch_slice(c, CNT_W);

    logic             ch_out_valid;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    if (DEPTH == 0) begin : g_wire
      assign ch_out_valid              = in_valid[c] & ~flush;
      assign in_ready[c]               = out_ready[c] & ~flush;
      assign out_data[DLO +: WIDTH]    = in_data[DLO +: WIDTH];
    end else begin : g_pipe
      // Per-stage signals keep the combinational ready chain free of self-loops.
      for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        logic             vld;
        logic [WIDTH-1:0] dat;
        logic             up_rdy;
        logic             dn_rdy;
        logic             up_vld;
        logic [WIDTH-1:0] up_dat;

        if (i == 0) begin : g_head
          assign up_vld = in_valid[c];
          assign up_dat = in_data[DLO +: WIDTH];
        end else begin : g_body
          assign up_vld = g_stage[i-1].vld;
          assign up_dat = g_stage[i-1].dat;
        end

        if (i == DEPTH - 1) begin : g_tail
          assign dn_rdy = out_ready[c];
        end else begin : g_link
          assign dn_rdy = g_stage[i+1].up_rdy;
        end

        fixup_pipe_stage #(
          .WIDTH (WIDTH)
        ) u_stage (
          .clk      (clk),
          .rst      (rst),
          .flush    (flush),
          .up_valid (up_vld),
          .up_data  (up_dat),
          .dn_ready (dn_rdy),
          .valid    (vld),
          .data     (dat),
          .up_ready (up_rdy)
        );
      end

      assign in_ready[c]            = g_stage[0].up_rdy & ~flush;
      assign ch_out_valid           = g_stage[DEPTH-1].vld & ~flush;
      assign out_data[DLO +: WIDTH] = g_stage[DEPTH-1].dat;
    end

    always_comb begin
      cnt_d = cnt_q;
      if (ch_out_valid & out_ready[c]) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_d;
      end
    end

    assign out_valid[c]           = ch_out_valid;
    assign xfer_cnt[CLO +: CNT_W] = cnt_q;
  end

endmodule

`default_nettype wire

// File: tb/tb_fixup_chan_pipe.sv
// ============================================================================
// tb_fixup_chan_pipe : scoreboard bench for a DEPTH=2 and a DEPTH=0 build
// Revision           : 1.0
// ============================================================================
`default_nettype none

module tb_fixup_chan_pipe;

  localparam int W   = 8;
  localparam int NC  = 4;
  localparam int D   = 2;
  localparam int CW  = 4;
  localparam int ZCW = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst, flush;
  logic [NC-1:0]     in_valid, in_ready, out_valid, out_ready;
  logic [NC*W-1:0]   in_data, out_data;
  logic [NC*CW-1:0]  xfer_cnt;

  logic [NC-1:0]     z_in_valid, z_in_ready, z_out_valid, z_out_ready;
  logic              z_flush;
  logic [NC*W-1:0]   z_in_data, z_out_data;
  logic [NC*ZCW-1:0] z_xfer_cnt;

  fixup_chan_pipe #(.WIDTH(W), .NUM_CH(NC), .DEPTH(D), .CNT_W(CW)) u_dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .xfer_cnt(xfer_cnt)
  );

  fixup_chan_pipe #(.WIDTH(W), .NUM_CH(NC), .DEPTH(0), .CNT_W(ZCW)) u_wire (
    .clk(clk), .rst(rst), .flush(z_flush),
    .in_valid(z_in_valid), .in_ready(z_in_ready), .in_data(z_in_data),
    .out_valid(z_out_valid), .out_ready(z_out_ready), .out_data(z_out_data),
    .xfer_cnt(z_xfer_cnt)
  );

  int           n_tests = 0;
  int           n_fail  = 0;
  int           acc [NC];
  int           cyc = 0;
  logic [W-1:0] exp_q [NC][$];
  logic [W-1:0] mon_exp;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every output handshake pops the oldest expected beat.
  always @(negedge clk) begin
    if (!rst) begin
      for (int c = 0; c < NC; c++) begin
        if (out_valid[c] && out_ready[c]) begin
          if (exp_q[c].size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL ch%0d unexpected beat: got 0x%0h, expected none", c, out_data[c*W +: W]);
          end else begin
            mon_exp = exp_q[c].pop_front();
            check($sformatf("ch%0d data", c), 64'(out_data[c*W +: W]), 64'(mon_exp));
          end
        end
      end
    end
  end

  task automatic send(input int c, input logic [W-1:0] val);
    bit done = 1'b0;
    in_valid[c]       = 1'b1;
    in_data[c*W +: W] = val;
    for (int k = 0; k < 20 && !done; k++) begin
      @(negedge clk);
      if (in_ready[c]) begin
        exp_q[c].push_back(val);
        acc[c]++;
        done = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    in_valid[c] = 1'b0;
    if (!done) begin
      n_tests++;
      n_fail++;
      $display("FAIL send ch%0d timeout: got in_ready=0, expected accept within 20 cycles", c);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    int zexp [NC];
    for (int c = 0; c < NC; c++) begin
      acc[c]  = 0;
      zexp[c] = 0;
    end

    // Reset with traffic offered
    rst = 1'b1; flush = 1'b0;
    in_valid = '1; in_data = 32'hDEADBEEF; out_ready = '0;
    z_flush = 1'b0; z_in_valid = '0; z_in_data = '0; z_out_ready = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset in_ready",  64'(in_ready),  64'hF);
    check("reset out_valid", 64'(out_valid), 64'h0);
    check("reset out_data",  64'(out_data),  64'h0);
    check("reset xfer_cnt",  64'(xfer_cnt),  64'h0);
    check("reset z_xfer",    64'(z_xfer_cnt), 64'h0);
    @(posedge clk); #1;
    rst = 1'b0; in_valid = '0; out_ready = '1;

    // Latency: one beat on ch0
    send(0, 8'hA5);
    @(negedge clk);
    check("lat first edge out_valid", 64'(out_valid), 64'h0);
    @(posedge clk); #1;
    @(negedge clk);
    check("lat out_valid", 64'(out_valid), 64'h1);
    check("lat out_data",  64'(out_data[W-1:0]), 64'hA5);
    @(posedge clk); #1;

    // Backpressure on ch1
    out_ready[1] = 1'b0;
    fork
      begin
        for (int k = 1; k <= 5; k++) send(1, W'(k));
      end
      begin
        repeat (4) @(negedge clk);
        check("bp in_ready",    64'(in_ready[1]), 64'h0);
        check("bp accepts",     64'(acc[1]), 64'd2);
        check("bp head valid",  64'(out_valid[1]), 64'h1);
        check("bp head data",   64'(out_data[W +: W]), 64'h01);
        @(posedge clk); #1;
        out_ready[1] = 1'b1;
      end
    join
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("bp xfer_cnt ch1", 64'(xfer_cnt[CW +: CW]), 64'd5);
    check("bp queue drained", 64'(exp_q[1].size()), 64'd0);
    @(posedge clk); #1;

    // Flush with two beats held in ch2
    out_ready[2] = 1'b0;
    send(2, 8'h11);
    send(2, 8'h22);
    flush = 1'b1;
    in_valid[2] = 1'b1; in_data[2*W +: W] = 8'h33; out_ready[2] = 1'b1;
    @(negedge clk);
    check("flush in_ready",  64'(in_ready),  64'h0);
    check("flush out_valid", 64'(out_valid), 64'h0);
    @(posedge clk); #1;
    flush = 1'b0; in_valid[2] = 1'b0;
    exp_q[2].delete();
    @(negedge clk);
    check("post-flush out_valid ch2", 64'(out_valid[2]), 64'h0);
    check("post-flush xfer ch2",      64'(xfer_cnt[2*CW +: CW]), 64'd0);
    check("post-flush in_ready ch2",  64'(in_ready[2]), 64'h1);
    @(posedge clk); #1;
    send(2, 8'h44);

    // Counter wrap and full throughput on ch3
    c0 = cyc;
    for (int k = 0; k < 17; k++) send(3, W'(8'h80 + k));
    check("ch3 throughput cycles", 64'(cyc - c0), 64'd17);
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("wrap xfer ch3",  64'(xfer_cnt[3*CW +: CW]), 64'd1);
    check("final xfer ch0", 64'(xfer_cnt[0 +: CW]),   64'd1);
    check("final xfer ch1", 64'(xfer_cnt[CW +: CW]),  64'd5);
    check("final xfer ch2", 64'(xfer_cnt[2*CW +: CW]), 64'd1);
    for (int c = 0; c < NC; c++)
      check($sformatf("queue empty ch%0d", c), 64'(exp_q[c].size()), 64'd0);

    // DEPTH=0 build mirrors inputs combinationally
    for (int i = 0; i < 16; i++) begin
      @(posedge clk); #1;
      z_flush     = (i % 5 == 4);
      z_in_valid  = NC'($urandom);
      z_out_ready = NC'($urandom);
      z_in_data   = $urandom;
      #1;
      check("z out_valid", 64'(z_out_valid), 64'(z_in_valid & ~{NC{z_flush}}));
      check("z out_data",  64'(z_out_data),  64'(z_in_data));
      check("z in_ready",  64'(z_in_ready),  64'(z_out_ready & ~{NC{z_flush}}));
      for (int c = 0; c < NC; c++)
        if (z_in_valid[c] && z_out_ready[c] && !z_flush) zexp[c]++;
    end
    @(posedge clk); #1;
    z_in_valid = '0; z_out_ready = '0;
    @(negedge clk);
    for (int c = 0; c < NC; c++)
      check($sformatf("z xfer ch%0d", c), 64'(z_xfer_cnt[c*ZCW +: ZCW]), 64'(zexp[c]));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
